// File: rtl/lcd_char_ctrl_if.sv
// LSU-side bus of the LCD character controller: store strobe/word in,
// polled status word and busy flag out.
interface lcd_char_ctrl_if;
  logic        i_wr;
  logic [31:0] i_wdata;
  logic [31:0] o_status;
  logic        o_busy;

  modport master (output i_wr, output i_wdata, input o_status, input o_busy);
  modport slave  (input i_wr, input i_wdata, output o_status, output o_busy);
endinterface

// File: rtl/lcd_char_ctrl.sv
// HD44780 write-only bus sequencer: autonomous power-up init, then drains
// CPU stores from a small FIFO as timed SETUP / EN_HI / HOLD / WAIT cycles.
module lcd_char_ctrl #(
  parameter int DEPTH   = 4,
  parameter int T_PWRUP = 750000,
  parameter int T_SETUP = 4,
  parameter int T_EN_HI = 12,
  parameter int T_HOLD  = 4,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  lcd_char_ctrl_if.slave  bus,
  output logic [7:0]      o_lcd_data,
  output logic            o_lcd_rs,
  output logic            o_lcd_rw,
  output logic            o_lcd_en,
  output logic            o_lcd_on,
  output logic            o_lcd_blon
);

  function automatic int max_phase();
    int m;
    m = T_PWRUP;
    if (T_CLR   > m) m = T_CLR;
    if (T_CMD   > m) m = T_CMD;
    if (T_SETUP > m) m = T_SETUP;
    if (T_EN_HI > m) m = T_EN_HI;
    if (T_HOLD  > m) m = T_HOLD;
    return m;
  endfunction

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h38;
      3'd3:             return 8'h08;
      3'd4:             return 8'h01;
      3'd5:             return 8'h06;
      3'd6:             return 8'h0C;
      default:          return 8'h00;
    endcase
  endfunction

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(max_phase() + 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, len_m1_s;
  logic [2:0]    step_q, step_d;
  logic          init_done_q, init_done_d, ovf_q, ovf_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d, en_q, en_d, on_q, on_d, blon_q, blon_d;
  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    mem_d [DEPTH];
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_s;
  logic          empty_s, full_s, pop_s, push_req_s, push_s, last_s, clr_s, busy_s;
  logic [8:0]    head_s;
  logic          unused_wdata_s;

  assign unused_wdata_s = ^bus.i_wdata[28:9];

  assign count_s = wptr_q - rptr_q;
  assign empty_s = (count_s == {(AW+1){1'b0}});
  assign full_s  = count_s[AW];
  assign head_s  = mem_q[rptr_q[AW-1:0]];
  // Clear/home need the long post-write wait.
  assign clr_s   = ~rs_q & ((data_q == 8'h01) | (data_q == 8'h02) | (data_q == 8'h03));

  // Phase length of the current state, minus one.
  always_comb begin
    len_m1_s = {CW{1'b0}};
    case (state_q)
      S_PWRUP: len_m1_s = CW'(T_PWRUP - 1);
      S_SETUP: len_m1_s = CW'(T_SETUP - 1);
      S_EN_HI: len_m1_s = CW'(T_EN_HI - 1);
      S_HOLD:  len_m1_s = CW'(T_HOLD - 1);
      S_WAIT:  len_m1_s = clr_s ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
      default: len_m1_s = {CW{1'b0}};
    endcase
  end

  assign last_s = (cnt_q == len_m1_s);

  // Sequencer next-state; output data/RS load only on entry to SETUP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(32'd1);
    step_d      = step_q;
    init_done_d = init_done_q;
    data_d      = data_q;
    rs_d        = rs_q;
    pop_s       = 1'b0;
    case (state_q)
      S_PWRUP: begin
        if (last_s) begin
          state_d = S_INIT;
          cnt_d   = {CW{1'b0}};
          step_d  = 3'd0;
        end else begin
          state_d = S_PWRUP;
        end
      end
      S_INIT: begin
        data_d  = init_rom(step_q);
        rs_d    = 1'b0;
        state_d = S_SETUP;
        cnt_d   = {CW{1'b0}};
      end
      S_IDLE: begin
        cnt_d = {CW{1'b0}};
        if (!empty_s) begin
          pop_s          = 1'b1;
          {rs_d, data_d} = head_s;
          state_d        = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (last_s) begin
          state_d = S_EN_HI;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_SETUP;
        end
      end
      S_EN_HI: begin
        if (last_s) begin
          state_d = S_HOLD;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_EN_HI;
        end
      end
      S_HOLD: begin
        if (last_s) begin
          state_d = S_WAIT;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_HOLD;
        end
      end
      S_WAIT: begin
        if (last_s) begin
          cnt_d = {CW{1'b0}};
          if (init_done_q) begin
            state_d = S_IDLE;
          end else if (step_q == 3'd6) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = S_INIT;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = {CW{1'b0}};
      end
    endcase
    en_d = (state_d == S_EN_HI);
  end

  // FIFO push/overflow and panel power/backlight capture.
  always_comb begin
    push_req_s = bus.i_wr & ~bus.i_wdata[29];
    // A pop in the same cycle frees the slot, so a push on full is accepted.
    push_s     = push_req_s & (~full_s | pop_s);
    if (push_req_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else if (bus.i_wr && bus.i_wdata[29] && (bus.i_wdata[7:0] == 8'hFF)) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (bus.i_wr) begin
      on_d   = bus.i_wdata[31];
      blon_d = bus.i_wdata[30];
    end else begin
      on_d   = on_q;
      blon_d = blon_q;
    end
  end

  // FIFO storage and pointers.
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wptr_q[AW-1:0]] = {bus.i_wdata[8], bus.i_wdata[7:0]};
      wptr_d                = wptr_q + (AW+1)'(32'd1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + (AW+1)'(32'd1);
    end else begin
      rptr_d = rptr_q;
    end
  end

  // State registers; reset aborts any bus cycle and flushes the FIFO.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_PWRUP;
      cnt_q       <= {CW{1'b0}};
      step_q      <= 3'd0;
      init_done_q <= 1'b0;
      ovf_q       <= 1'b0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      on_q        <= 1'b0;
      blon_q      <= 1'b0;
      wptr_q      <= {(AW+1){1'b0}};
      rptr_q      <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 9'h000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      init_done_q <= init_done_d;
      ovf_q       <= ovf_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      en_q        <= en_d;
      on_q        <= on_d;
      blon_q      <= blon_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      mem_q       <= mem_d;
    end
  end

  // Busy is masked while reset is held so every output reads zero in reset.
  assign busy_s       = i_reset & ((state_q != S_IDLE) | ~empty_s);
  assign bus.o_busy   = busy_s;
  assign bus.o_status = {busy_s, init_done_q, ovf_q, 21'd0, 8'(count_s)};
  assign o_lcd_data   = data_q;
  assign o_lcd_rs     = rs_q;
  assign o_lcd_rw     = 1'b0;
  assign o_lcd_en     = en_q;
  assign o_lcd_on     = on_q;
  assign o_lcd_blon   = blon_q;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Randomised bench for lcd_char_ctrl: a transfer-level timeline model predicts
// every output each cycle, plus directed init/overflow/gap/reset scenarios.
module tb_lcd_char_ctrl;
  localparam int DEPTH = 4, T_PWRUP = 10, T_SETUP = 3, T_EN_HI = 5, T_HOLD = 2;
  localparam int T_CMD = 5, T_CLR = 8, PER = 10;

  logic       i_clk, i_reset;
  logic [7:0] o_lcd_data;
  logic       o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_blon;

  lcd_char_ctrl_if bus ();

  lcd_char_ctrl #(
    .DEPTH(DEPTH), .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_EN_HI(T_EN_HI),
    .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .bus(bus),
    .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
    .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on), .o_lcd_blon(o_lcd_blon)
  );

  initial i_clk = 1'b0;
  always #(PER/2) i_clk = ~i_clk;

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: 0 = power-up wait, 1 = between transfers, 2 = transfer in flight.
  logic [7:0] init_bytes [7] = '{8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  int         m_st, m_pw, m_el, m_wl, m_step;
  logic [8:0] m_cur;
  logic [8:0] m_q [$];
  logic       m_done, m_ovf, m_on, m_blon;

  task automatic m_reset();
    m_st = 0; m_pw = T_PWRUP; m_el = 0; m_wl = 0; m_step = 0;
    m_cur = 9'h000; m_q.delete();
    m_done = 1'b0; m_ovf = 1'b0; m_on = 1'b0; m_blon = 1'b0;
  endtask

  task automatic m_start(input logic [8:0] b);
    m_cur = b; m_st = 2; m_el = 0;
    m_wl = (!b[8] && b[7:0] >= 8'h01 && b[7:0] <= 8'h03) ? T_CLR : T_CMD;
  endtask

  task automatic m_step_clk(input logic wr, input logic [31:0] w);
    int  sz_pre;
    bit  pop;
    sz_pre = m_q.size();
    pop    = 1'b0;
    if (m_st == 0) begin
      if (m_pw == 1) m_st = 1; else m_pw--;
    end else if (m_st == 1) begin
      if (!m_done) begin
        m_start({1'b0, init_bytes[m_step]});
        m_step++;
      end else if (m_q.size() > 0) begin
        pop = 1'b1;
        m_start(m_q.pop_front());
      end
    end else begin
      if (m_el == T_SETUP + T_EN_HI + T_HOLD + m_wl - 1) begin
        m_st = 1;
        if (!m_done && m_step == 7) m_done = 1'b1;
      end else begin
        m_el++;
      end
    end
    if (wr && !w[29]) begin
      if (sz_pre == DEPTH && !pop) m_ovf = 1'b1;
      else m_q.push_back({w[8], w[7:0]});
    end else if (wr && w[7:0] == 8'hFF) begin
      m_ovf = 1'b0;
    end
    if (wr) begin
      m_on = w[31]; m_blon = w[30];
    end
  endtask

  function automatic logic [63:0] exp_vec();
    logic        busy, en;
    logic [31:0] st;
    busy = i_reset && (!(m_st == 1 && m_done) || m_q.size() != 0);
    en   = (m_st == 2) && (m_el >= T_SETUP) && (m_el < T_SETUP + T_EN_HI);
    st   = {busy, m_done, m_ovf, 21'd0, 8'(m_q.size())};
    return {18'd0, st, busy, en, m_cur[8], 1'b0, m_cur[7:0], m_on, m_blon};
  endfunction

  // Cycle-by-cycle comparison of every output against the model.
  always @(posedge i_clk) begin
    if (!i_reset) m_reset();
    else m_step_clk(bus.i_wr, bus.i_wdata);
    #1;
    check_eq("outs", {18'd0, bus.o_status, bus.o_busy, o_lcd_en, o_lcd_rs, o_lcd_rw,
                      o_lcd_data, o_lcd_on, o_lcd_blon}, exp_vec());
  end

  // Pulse monitor: byte latched at EN rise, time of each EN fall.
  logic [8:0] got_q [$];
  longint     fall_t [$];
  logic       prev_en = 1'b0;
  always @(posedge i_clk) begin
    #1;
    if (i_reset && o_lcd_en && !prev_en) got_q.push_back({o_lcd_rs, o_lcd_data});
    if (i_reset && !o_lcd_en && prev_en) fall_t.push_back($time);
    prev_en = o_lcd_en;
  end

  task automatic wr_word(input logic [31:0] w);
    bus.i_wr = 1'b1; bus.i_wdata = w;
    @(negedge i_clk);
    bus.i_wr = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (bus.o_busy && n < lim) begin @(negedge i_clk); n++; end
    check_eq("idle_timeout", 64'(n < lim), 64'd1);
  endtask

  task automatic wait_init(input int lim);
    int n = 0;
    while (!bus.o_status[30] && n < lim) begin @(negedge i_clk); n++; end
    check_eq("init_timeout", 64'(n < lim), 64'd1);
  endtask

  task automatic check_init_pulses();
    check_eq("init_npulse", 64'(got_q.size()), 64'd7);
    for (int i = 0; i < 7 && i < got_q.size(); i++)
      check_eq("init_byte", 64'(got_q[i]), 64'({1'b0, init_bytes[i]}));
  endtask

  initial begin
    logic [31:0] w;
    int          n;
    i_reset = 1'b0; bus.i_wr = 1'b0; bus.i_wdata = 32'h0;
    repeat (3) @(negedge i_clk);
    check_eq("rst_outs", {56'd0, o_lcd_data} | {o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_blon},
             64'd0);
    check_eq("rst_status", 64'(bus.o_status), 64'd0);
    i_reset = 1'b1;

    // Power-up init sequence
    got_q.delete();
    wait_init(400);
    check_init_pulses();

    // Single data write with power/backlight
    wr_word(32'hC000_0141);
    check_eq("on_blon", 64'({o_lcd_on, o_lcd_blon}), 64'd3);
    got_q.delete();
    wait_idle(200);
    check_eq("one_pulse", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check_eq("one_byte", 64'(got_q[0]), 64'h141);

    // Six writes: one pops, four queue, one dropped
    got_q.delete();
    for (int i = 0; i < 6; i++) wr_word(32'h0000_0130 + 32'(i));
    check_eq("ovf_set", 64'(bus.o_status[29]), 64'd1);
    check_eq("cnt_peak", 64'(bus.o_status[7:0]), 64'(DEPTH));
    wait_idle(500);
    check_eq("burst_npulse", 64'(got_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      check_eq("burst_order", 64'(got_q[i]), 64'(9'h130 + 9'(i)));
    wr_word(32'h2000_00FF);
    check_eq("ovf_clr", 64'(bus.o_status[29]), 64'd0);

    // Clear-class command followed by data: EN fall gap
    fall_t.delete();
    wr_word(32'h0000_0002);
    wr_word(32'h0000_0158);
    wait_idle(200);
    check_eq("gap_n", 64'(fall_t.size()), 64'd2);
    if (fall_t.size() >= 2)
      check_eq("gap_len", 64'((fall_t[1] - fall_t[0]) / PER),
               64'(T_HOLD + T_CLR + 1 + T_SETUP + T_EN_HI));

    // Push on the very cycle IDLE pops a full FIFO
    for (int i = 0; i < 5; i++) wr_word(32'h0000_0160 + 32'(i));
    n = 0;
    while (!(m_st == 1 && m_done && m_q.size() == DEPTH) && n < 200) begin
      @(negedge i_clk); n++;
    end
    check_eq("full_pop_seen", 64'(n < 200), 64'd1);
    wr_word(32'h0000_0177);
    check_eq("full_pop_ovf", 64'(bus.o_status[29]), 64'd0);
    check_eq("full_pop_cnt", 64'(bus.o_status[7:0]), 64'(DEPTH));
    wait_idle(500);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[29] = 1'b0;
      if ($urandom_range(0, 15) == 0) w[7:0] = 8'hFF;
      bus.i_wr = ($urandom_range(0, 3) == 0);
      bus.i_wdata = w;
      @(negedge i_clk);
    end
    bus.i_wr = 1'b0;
    wait_idle(2000);

    // Reset during EN high of a FIFO transfer
    for (int i = 0; i < 3; i++) wr_word(32'h0000_0121 + 32'(i));
    n = 0;
    while (!o_lcd_en && n < 100) begin @(negedge i_clk); n++; end
    check_eq("en_seen", 64'(o_lcd_en), 64'd1);
    #2 i_reset = 1'b0;
    #1;
    check_eq("rst_en_async", 64'(o_lcd_en), 64'd0);
    check_eq("rst_cnt_async", 64'(bus.o_status[7:0]), 64'd0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    got_q.delete();
    wait_init(400);
    check_init_pulses();
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
